arbitro_sumador: RTL and testbench

ARBITRO_SUMADOR -- requirements
Module: arbitro_sumador

---
 rtl/arbitro_sumador_pkg.sv | 24 ++
 rtl/sumador_selectivo.sv | 27 ++
 rtl/arbitro_sumador.sv | 130 +++++++++++++
 tb/tb_arbitro_sumador.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_sumador_pkg.sv
// Shared definitions for the request arbiter and selective adder.
// Contents:
//   - operand, result and select widths (3-bit operands, 4-bit result, 2-bit select)
//   - operation-select codes
//   - FSM state encoding
package arbitro_sumador_pkg;

    localparam int unsigned NB_OPERAND = 3;
    localparam int unsigned NB_RESULT  = 4;
    localparam int unsigned NB_SEL     = 2;
    localparam int unsigned N_REQ      = 2;

    localparam logic [NB_SEL-1:0] SEL_DATA2 = 2'b00;
    localparam logic [NB_SEL-1:0] SEL_SUMA  = 2'b01;
    localparam logic [NB_SEL-1:0] SEL_DATA1 = 2'b10;
    localparam logic [NB_SEL-1:0] SEL_CERO  = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

endpackage

// File: rtl/sumador_selectivo.sv
// Combinational selective adder.
// Ports:
//   data1_i  operand 1 (3 bits)
//   data2_i  operand 2 (3 bits)
//   sel_i    operation select: 00 data2, 01 data1+data2, 10 data1, 11 zero
//   suma_o   4-bit result, wide enough that the sum never overflows
module sumador_selectivo
    import arbitro_sumador_pkg::*;
(
    input  logic [NB_OPERAND-1:0] data1_i,
    input  logic [NB_OPERAND-1:0] data2_i,
    input  logic [NB_SEL-1:0]     sel_i,
    output logic [NB_RESULT-1:0]  suma_o
);

    always_comb begin
        suma_o = '0;
        unique case (sel_i)
            SEL_DATA2: suma_o = {1'b0, data2_i};
            SEL_SUMA:  suma_o = {1'b0, data1_i} + {1'b0, data2_i};
            SEL_DATA1: suma_o = {1'b0, data1_i};
            SEL_CERO:  suma_o = '0;
            default:   suma_o = '0;
        endcase
    end

endmodule

// File: rtl/arbitro_sumador.sv
// Two-requester arbiter in front of a selective adder, with a valid/ready
// request side, a valid/ready response side and a served-operation counter.
// Ports:
//   i_clock, i_reset          clock; synchronous active-high reset
//   i_req_valid[1:0]          per-requester request valid
//   i_req_data1[5:0]          operand 1, requester k on [3k+2:3k]
//   i_req_data2[5:0]          operand 2, same packing
//   i_req_sel[3:0]            operation select, requester k on [2k+1:2k]
//   o_req_ready[1:0]          one-hot grant, only in IDLE
//   o_rsp_valid/suma/id       registered result, owner id
//   i_rsp_ready               consumer ready
//   o_ops_count[NB_COUNT-1:0] completed response transfers (wraps)
// Configuration:
//   ARBITRO_ROUND_ROBIN_EN    defined: round-robin on contention;
//                             undefined: requester 0 always wins contention.
module arbitro_sumador
    import arbitro_sumador_pkg::*;
#(
    parameter int unsigned NB_COUNT = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [1:0]            i_req_valid,
    input  logic [5:0]            i_req_data1,
    input  logic [5:0]            i_req_data2,
    input  logic [3:0]            i_req_sel,
    output logic [1:0]            o_req_ready,
    output logic                  o_rsp_valid,
    output logic [3:0]            o_rsp_suma,
    output logic                  o_rsp_id,
    input  logic                  i_rsp_ready,
    output logic [NB_COUNT-1:0]   o_ops_count
);

    state_e                state_q;
    logic                  ptr_q;
    logic [NB_OPERAND-1:0] data1_q;
    logic [NB_OPERAND-1:0] data2_q;
    logic [NB_SEL-1:0]     sel_q;
    logic                  id_q;

    logic                  grant_id;
    logic                  ptr_d;
    logic                  req_fire;
    logic [NB_OPERAND-1:0] data1_grant;
    logic [NB_OPERAND-1:0] data2_grant;
    logic [NB_SEL-1:0]     sel_grant;
    logic [NB_RESULT-1:0]  suma;

    // Grant: a lone requester always wins; the pointer only breaks ties.
    always_comb begin
        grant_id = 1'b0;
        unique case (i_req_valid)
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ptr_q;
            default: grant_id = 1'b0;
        endcase
    end

    // Ready is suppressed while reset is high so no handshake can appear to
    // win against reset at the same edge.
    always_comb begin
        o_req_ready = 2'b00;
        if (state_q == StIdle && !i_reset && (|i_req_valid)) begin
            o_req_ready = grant_id ? 2'b10 : 2'b01;
        end
    end

    assign req_fire = |(i_req_valid & o_req_ready);

    assign data1_grant = grant_id ? i_req_data1[5:3] : i_req_data1[2:0];
    assign data2_grant = grant_id ? i_req_data2[5:3] : i_req_data2[2:0];
    assign sel_grant   = grant_id ? i_req_sel[3:2]   : i_req_sel[1:0];

`ifdef ARBITRO_ROUND_ROBIN_EN
    assign ptr_d = ~grant_id;
`else
    assign ptr_d = 1'b0;
`endif

    sumador_selectivo u_sumador (
        .data1_i (data1_q),
        .data2_i (data2_q),
        .sel_i   (sel_q),
        .suma_o  (suma)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            sel_q       <= '0;
            id_q        <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_suma  <= '0;
            o_rsp_id    <= 1'b0;
            o_ops_count <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        data1_q <= data1_grant;
                        data2_q <= data2_grant;
                        sel_q   <= sel_grant;
                        id_q    <= grant_id;
                        ptr_q   <= ptr_d;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    o_rsp_suma  <= suma;
                    o_rsp_id    <= id_q;
                    o_rsp_valid <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_ops_count <= o_ops_count + NB_COUNT'(1);
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Self-checking bench for arbitro_sumador: directed cases plus a random run,
// compared against an arithmetic reference model. A second instance with
// NB_COUNT=2 shares all inputs to exercise counter wrap.
module tb_arbitro_sumador;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic [1:0] i_req_valid;
    logic [5:0] i_req_data1;
    logic [5:0] i_req_data2;
    logic [3:0] i_req_sel;
    logic       i_rsp_ready;

    logic [1:0] o_req_ready;
    logic       o_rsp_valid;
    logic [3:0] o_rsp_suma;
    logic       o_rsp_id;
    logic [7:0] o_ops_count;

    logic [1:0] o_req_ready2;
    logic       o_rsp_valid2;
    logic [3:0] o_rsp_suma2;
    logic       o_rsp_id2;
    logic [1:0] o_ops_count2;

    int total = 0;
    int bad   = 0;
    int exp_count = 0;
    logic ptr = 1'b0;

    always #5 i_clock = ~i_clock;

    arbitro_sumador #(.NB_COUNT(8)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data1 (i_req_data1),
        .i_req_data2 (i_req_data2),
        .i_req_sel   (i_req_sel),
        .o_req_ready (o_req_ready),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_suma  (o_rsp_suma),
        .o_rsp_id    (o_rsp_id),
        .i_rsp_ready (i_rsp_ready),
        .o_ops_count (o_ops_count)
    );

    arbitro_sumador #(.NB_COUNT(2)) dut2 (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data1 (i_req_data1),
        .i_req_data2 (i_req_data2),
        .i_req_sel   (i_req_sel),
        .o_req_ready (o_req_ready2),
        .o_rsp_valid (o_rsp_valid2),
        .o_rsp_suma  (o_rsp_suma2),
        .o_rsp_id    (o_rsp_id2),
        .i_rsp_ready (i_rsp_ready),
        .o_ops_count (o_ops_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: the operation table written as plain arithmetic.
    function automatic logic [3:0] ref_op(input int d1, input int d2, input int sel);
        int r;
        case (sel)
            0:       r = d2;
            1:       r = d1 + d2;
            2:       r = d1;
            default: r = 0;
        endcase
        return 4'(r);
    endfunction

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_count(input string tag);
        check({tag, "_cnt"},  32'(o_ops_count),  32'(exp_count % 256));
        check({tag, "_cnt2"}, 32'(o_ops_count2), 32'(exp_count % 4));
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_req_valid = 2'b11;
        i_rsp_ready = 1'b1;
        tick();
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        i_reset     = 1'b0;
        i_req_valid = 2'b00;
        exp_count   = 0;
        ptr         = 1'b0;
        check_count("rst");
    endtask

    // One complete transaction; bp = cycles of response backpressure.
    task automatic run_op(input logic [1:0] v, input logic [5:0] d1, input logic [5:0] d2,
                          input logic [3:0] s, input int bp, input string tag);
        int g;
        logic [3:0] er;
        i_req_valid = v;
        i_req_data1 = d1;
        i_req_data2 = d2;
        i_req_sel   = s;
        i_rsp_ready = 1'($urandom);
        #1;
        g  = (v == 2'b11) ? int'(ptr) : (v[0] ? 0 : 1);
        er = ref_op(int'((d1 >> (3 * g)) & 6'd7), int'((d2 >> (3 * g)) & 6'd7),
                    int'((s >> (2 * g)) & 4'd3));
        check({tag, "_grant"}, 32'(o_req_ready), (g == 1) ? 32'd2 : 32'd1);
        tick();
`ifdef ARBITRO_ROUND_ROBIN_EN
        ptr = (g == 0);
`else
        ptr = 1'b0;
`endif
        // In EXEC: request inputs must no longer matter.
        i_req_valid = 2'($urandom);
        i_req_data1 = 6'($urandom);
        i_req_data2 = 6'($urandom);
        i_req_sel   = 4'($urandom);
        i_rsp_ready = 1'($urandom);
        #1;
        check({tag, "_exec_ready"}, 32'(o_req_ready), 32'd0);
        check({tag, "_exec_valid"}, 32'(o_rsp_valid), 32'd0);
        tick();
        i_rsp_ready = 1'b0;
        for (int i = 0; i <= bp; i++) begin
            #1;
            check({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
            check({tag, "_suma"},  32'(o_rsp_suma),  32'(er));
            check({tag, "_id"},    32'(o_rsp_id),    32'(g));
            check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
            check_count(tag);
            if (i < bp) begin
                i_req_valid = 2'($urandom);
                tick();
            end
        end
        i_rsp_ready = 1'b1;
        tick();
        exp_count++;
        check({tag, "_done_valid"}, 32'(o_rsp_valid), 32'd0);
        check_count({tag, "_done"});
        i_rsp_ready = 1'($urandom);
    endtask

    // Abort a transaction with reset in EXEC (phase 0) or RESP (phase 1).
    task automatic reset_mid(input int phase, input string tag);
        i_req_valid = 2'b01;
        i_req_data1 = 6'o07;
        i_req_data2 = 6'o07;
        i_req_sel   = 4'b0101;
        i_rsp_ready = 1'b1;
        #1;
        check({tag, "_grant"}, 32'(o_req_ready), 32'd1);
        tick();
        if (phase == 1) begin
            tick();
            check({tag, "_in_resp"}, 32'(o_rsp_valid), 32'd1);
        end
        i_reset     = 1'b1;
        i_req_valid = 2'b11;
        i_rsp_ready = 1'b1;
        tick();
        check({tag, "_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_suma"},  32'(o_rsp_suma),  32'd0);
        check({tag, "_ready"}, 32'(o_req_ready), 32'd0);
        exp_count = 0;
        ptr       = 1'b0;
        check_count(tag);
        i_reset = 1'b0;
        // Pointer was cleared: contention must go to requester 0.
        run_op(2'b11, 6'o12, 6'o34, 4'b0110, 0, {tag, "_after"});
    endtask

    initial begin
        i_reset     = 1'b1;
        i_req_valid = 2'b00;
        i_req_data1 = '0;
        i_req_data2 = '0;
        i_req_sel   = '0;
        i_rsp_ready = 1'b0;
        tick();
        tick();
        check("init_valid", 32'(o_rsp_valid), 32'd0);
        check("init_suma",  32'(o_rsp_suma),  32'd0);
        check("init_id",    32'(o_rsp_id),    32'd0);
        check_count("init");
        do_reset();

        // Idle with no requests: no grant, nothing happens.
        i_req_valid = 2'b00;
        i_rsp_ready = 1'b1;
        #1;
        check("idle_ready", 32'(o_req_ready), 32'd0);
        tick();
        tick();
        check("idle_valid", 32'(o_rsp_valid), 32'd0);
        check_count("idle");

        // Basic and boundary operations.
        run_op(2'b01, 6'o03, 6'o04, 4'b0001, 0, "add_3_4");
        run_op(2'b01, 6'o07, 6'o07, 4'b0001, 0, "add_7_7");
        run_op(2'b01, 6'o07, 6'o07, 4'b0011, 0, "sel_cero");
        run_op(2'b01, 6'o05, 6'o02, 4'b0010, 0, "sel_d1");
        run_op(2'b01, 6'o01, 6'o06, 4'b0000, 0, "sel_d2");
        run_op(2'b10, 6'o61, 6'o72, 4'b0100, 0, "req1_add");
        run_op(2'b10, 6'o50, 6'o30, 4'b1000, 0, "req1_d1");

        // Continuous contention from reset.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_op(2'b11, 6'($urandom), 6'($urandom), 4'($urandom), 0, "contend");
        end

        // Backpressure.
        run_op(2'b01, 6'o02, 6'o05, 4'b0001, 5, "bp5");

        reset_mid(0, "rst_exec");
        reset_mid(1, "rst_resp");

        // Random traffic, long enough to wrap both counters.
        for (int k = 0; k < 300; k++) begin
            run_op(2'($urandom_range(1, 3)), 6'($urandom), 6'($urandom), 4'($urandom),
                   int'($urandom_range(0, 2)), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
